// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must be able to hold bit_width itself.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit combinational full subtractor: x - y - bin.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - borrow_in LSB first, one bit per
// clock, through a single full_sub cell.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int bit_width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [bit_width-1:0] a,
    input  logic [bit_width-1:0] b,
    input  logic                 borrow_in,
    output logic                 busy,
    output logic                 done,
    output logic [bit_width-1:0] d,
    output logic                 borrow_out
);

    localparam int CNT_W = cnt_w(bit_width);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(bit_width - 1);

    state_t                 state_reg, state_next;
    logic [bit_width-1:0]   a_reg, a_next;
    logic [bit_width-1:0]   b_reg, b_next;
    logic [bit_width-1:0]   res_reg, res_next;
    logic                   br_reg, br_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [bit_width-1:0]   d_reg, d_next;
    logic                   bo_reg, bo_next;

    logic cell_diff;
    logic cell_bout;

    full_sub u_cell (
        .x    (a_reg[0]),
        .y    (b_reg[0]),
        .bin  (br_reg),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            d_reg     <= '0;
            bo_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            res_reg   <= res_next;
            br_reg    <= br_next;
            cnt_reg   <= cnt_next;
            d_reg     <= d_next;
            bo_reg    <= bo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        res_next   = res_reg;
        br_next    = br_reg;
        cnt_next   = cnt_reg;
        d_next     = d_reg;
        bo_next    = bo_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    a_next     = a;
                    b_next     = b;
                    br_next    = borrow_in;
                    res_next   = '0;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                a_next   = {1'b0, a_reg[bit_width-1:1]};
                b_next   = {1'b0, b_reg[bit_width-1:1]};
                res_next = {cell_diff, res_reg[bit_width-1:1]};
                br_next  = cell_bout;
                cnt_next = cnt_reg + CNT_W'(1);
                // Results are published only on the final bit, so d never shows partial sums.
                if (cnt_reg == LAST_CNT) begin
                    d_next     = {cell_diff, res_reg[bit_width-1:1]};
                    bo_next    = cell_bout;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == DONE);
    assign d          = d_reg;
    assign borrow_out = bo_reg;

endmodule
